// File: rtl/pe_pkg.sv
// Shared types for the two-PE Givens-rotation phase sequencer:
// scheme codes, FSM states, the schedule entry and the writeback record.
package pe_pkg;

  localparam logic [1:0] SCHEME_C2R   = 2'd0;
  localparam logic [1:0] SCHEME_CROT  = 2'd1;
  localparam logic [1:0] SCHEME_RNULL = 2'd2;
  localparam logic [1:0] SCHEME_RROT  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] scheme0;
    logic [1:0] scheme1;
    logic [1:0] row;
    logic [1:0] col;
    logic       fb;
    logic       swap;
  } step_entry_t;

  typedef struct packed {
    logic       v;
    logic [1:0] row;
    logic [1:0] col;
    logic       swap;
  } wb_rec_t;

  function automatic step_entry_t make_entry(input logic [1:0] s0, input logic [1:0] s1,
                                             input logic [1:0] row, input logic [1:0] col,
                                             input logic fb, input logic swap);
    step_entry_t e;
    e.valid   = 1'b1;
    e.scheme0 = s0;
    e.scheme1 = s1;
    e.row     = row;
    e.col     = col;
    e.fb      = fb;
    e.swap    = swap;
    return e;
  endfunction

endpackage

// File: rtl/pe_phase_sequencer_if.sv
// Control/address bundle between the phase sequencer (master) and the
// matrix-buffer top that consumes its PE and buffer controls (slave).
interface pe_phase_sequencer_if;

  logic       start_i;
  logic       abort_i;
  logic       busy_o;
  logic       done_o;
  logic [1:0] pe0_valid_o;
  logic [1:0] pe1_valid_o;
  logic [1:0] pe0_scheme_o;
  logic [1:0] pe1_scheme_o;
  logic       rd_en_o;
  logic       src_fb_o;
  logic       rd_swap_o;
  logic [1:0] rd_row_o;
  logic [1:0] rd_col_o;
  logic       wr_en_o;
  logic       wr_swap_o;
  logic [1:0] wr_row_o;
  logic [1:0] wr_col_o;

  modport master (
    input  start_i, abort_i,
    output busy_o, done_o, pe0_valid_o, pe1_valid_o, pe0_scheme_o, pe1_scheme_o,
           rd_en_o, src_fb_o, rd_swap_o, rd_row_o, rd_col_o,
           wr_en_o, wr_swap_o, wr_row_o, wr_col_o
  );

  modport slave (
    output start_i, abort_i,
    input  busy_o, done_o, pe0_valid_o, pe1_valid_o, pe0_scheme_o, pe1_scheme_o,
           rd_en_o, src_fb_o, rd_swap_o, rd_row_o, rd_col_o,
           wr_en_o, wr_swap_o, wr_row_o, wr_col_o
  );

endinterface

// File: rtl/pe_sched_rom.sv
// Combinational step -> schedule entry table for the 4x4 bidiagonalization.
// Unlisted steps are bubbles; swap this table to retarget other matrix sizes.
module pe_sched_rom
  import pe_pkg::*;
#(
  parameter int STEP_W = 4
) (
  input  logic [STEP_W-1:0] step,
  output step_entry_t       entry
);

  always_comb begin
    entry = '0;
    case (step)
      STEP_W'(0):  entry = make_entry(SCHEME_C2R,   SCHEME_CROT, 2'd0, 2'd0, 1'b0, 1'b0);
      STEP_W'(1):  entry = make_entry(SCHEME_CROT,  SCHEME_CROT, 2'd0, 2'd2, 1'b0, 1'b0);
      STEP_W'(2):  entry = make_entry(SCHEME_C2R,   SCHEME_CROT, 2'd2, 2'd0, 1'b0, 1'b0);
      STEP_W'(3):  entry = make_entry(SCHEME_CROT,  SCHEME_CROT, 2'd2, 2'd2, 1'b0, 1'b0);
      // Steps 4-7 are bubbles that let the column results return before feedback starts
      STEP_W'(8):  entry = make_entry(SCHEME_RNULL, SCHEME_RROT, 2'd0, 2'd0, 1'b1, 1'b0);
      STEP_W'(9):  entry = make_entry(SCHEME_RROT,  SCHEME_RROT, 2'd0, 2'd2, 1'b1, 1'b0);
      STEP_W'(10): entry = make_entry(SCHEME_RNULL, SCHEME_RROT, 2'd2, 2'd0, 1'b1, 1'b1);
      STEP_W'(11): entry = make_entry(SCHEME_RROT,  SCHEME_RROT, 2'd2, 2'd2, 1'b1, 1'b1);
      default:     entry = '0;
    endcase
  end

endmodule

// File: rtl/pe_phase_sequencer.sv
// Table-driven phase scheduler for the two-PE Givens datapath: issues ROM
// entries in RUN and replays them PE_LATENCY cycles later as buffer writebacks.
module pe_phase_sequencer
  import pe_pkg::*;
#(
  parameter int PE_LATENCY = 8,
  parameter int NUM_STEPS  = 12,
  parameter int STEP_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pe_phase_sequencer_if.master bus
);

  localparam int DRAIN_W = (PE_LATENCY > 1) ? $clog2(PE_LATENCY) : 1;

  seq_state_t        state;
  seq_state_t        state_next;
  logic [STEP_W-1:0] step;
  logic [DRAIN_W-1:0] drain_cnt;
  step_entry_t       entry;
  wb_rec_t           push_rec;
  wb_rec_t           tail;
  wb_rec_t           dl [PE_LATENCY];

  pe_sched_rom #(.STEP_W(STEP_W)) u_rom (
    .step  (step),
    .entry (entry)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next       = state;
    bus.busy_o       = 1'b0;
    bus.done_o       = 1'b0;
    bus.pe0_valid_o  = 2'b00;
    bus.pe1_valid_o  = 2'b00;
    bus.pe0_scheme_o = 2'b00;
    bus.pe1_scheme_o = 2'b00;
    bus.rd_en_o      = 1'b0;
    bus.src_fb_o     = 1'b0;
    bus.rd_swap_o    = 1'b0;
    bus.rd_row_o     = 2'b00;
    bus.rd_col_o     = 2'b00;
    push_rec         = '0;
    case (state)
      ST_IDLE: begin
        if (bus.start_i && !bus.abort_i) state_next = ST_RUN;
      end
      ST_RUN: begin
        bus.busy_o       = 1'b1;
        bus.pe0_valid_o  = {2{entry.valid}};
        bus.pe1_valid_o  = {2{entry.valid}};
        bus.pe0_scheme_o = entry.scheme0;
        bus.pe1_scheme_o = entry.scheme1;
        bus.rd_en_o      = entry.valid;
        bus.src_fb_o     = entry.fb;
        bus.rd_swap_o    = entry.swap;
        bus.rd_row_o     = entry.row;
        bus.rd_col_o     = entry.col;
        push_rec.v       = entry.valid;
        push_rec.row     = entry.row;
        push_rec.col     = entry.col;
        push_rec.swap    = entry.swap;
        if (bus.abort_i)                             state_next = ST_IDLE;
        else if (step == STEP_W'(NUM_STEPS - 1))     state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        bus.busy_o = 1'b1;
        if (bus.abort_i)                              state_next = ST_IDLE;
        else if (drain_cnt == DRAIN_W'(PE_LATENCY - 1)) state_next = ST_DONE;
      end
      ST_DONE: begin
        bus.done_o = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Counters restart whenever their phase is left, including on abort
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step      <= '0;
      drain_cnt <= '0;
    end else begin
      step      <= (state == ST_RUN   && state_next == ST_RUN)   ? step + 1'b1      : '0;
      drain_cnt <= (state == ST_DRAIN && state_next == ST_DRAIN) ? drain_cnt + 1'b1 : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || bus.abort_i) begin
      for (int i = 0; i < PE_LATENCY; i++) dl[i] <= '0;
    end else begin
      dl[0] <= push_rec;
      for (int i = 1; i < PE_LATENCY; i++) dl[i] <= dl[i-1];
    end
  end

  assign tail          = dl[PE_LATENCY-1];
  assign bus.wr_en_o   = tail.v;
  assign bus.wr_swap_o = tail.swap;
  assign bus.wr_row_o  = tail.row;
  assign bus.wr_col_o  = tail.col;

endmodule

// File: tb/tb_pe_phase_sequencer.sv
// Scoreboard bench: expected output bundles are queued per cycle from a
// schedule-table model and compared at each falling edge.
module tb_pe_phase_sequencer;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [1:0] pe0v;
    logic [1:0] pe1v;
    logic [1:0] s0;
    logic [1:0] s1;
    logic       rd_en;
    logic       src_fb;
    logic       rd_swap;
    logic [1:0] rd_row;
    logic [1:0] rd_col;
    logic       wr_en;
    logic       wr_swap;
    logic [1:0] wr_row;
    logic [1:0] wr_col;
  } out_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  out_t exp_q [$];

  int t_v    [12] = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1};
  int t_s0   [12] = '{0, 1, 0, 1, 0, 0, 0, 0, 2, 3, 2, 3};
  int t_s1   [12] = '{1, 1, 1, 1, 0, 0, 0, 0, 3, 3, 3, 3};
  int t_row  [12] = '{0, 0, 2, 2, 0, 0, 0, 0, 0, 0, 2, 2};
  int t_col  [12] = '{0, 2, 0, 2, 0, 0, 0, 0, 0, 2, 0, 2};
  int t_fb   [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
  int t_swap [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};

  pe_phase_sequencer_if bus8 ();
  pe_phase_sequencer_if bus3 ();

  pe_phase_sequencer #(.PE_LATENCY(8), .NUM_STEPS(12), .STEP_W(4)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  pe_phase_sequencer #(.PE_LATENCY(3), .NUM_STEPS(12), .STEP_W(4)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3)
  );

  always #5 clk = ~clk;

  // Expected bundle k cycles after the cycle in which start was sampled
  function automatic out_t model(input int k, input int lat);
    out_t o;
    int   s;
    int   w;
    o = '0;
    if (k >= 1 && k <= 12 + lat) o.busy = 1'b1;
    if (k == 13 + lat)           o.done = 1'b1;
    s = k - 1;
    if (s >= 0 && s < 12 && t_v[s] == 1) begin
      o.pe0v    = 2'b11;
      o.pe1v    = 2'b11;
      o.s0      = 2'(t_s0[s]);
      o.s1      = 2'(t_s1[s]);
      o.rd_en   = 1'b1;
      o.src_fb  = 1'(t_fb[s]);
      o.rd_swap = 1'(t_swap[s]);
      o.rd_row  = 2'(t_row[s]);
      o.rd_col  = 2'(t_col[s]);
    end
    w = k - 1 - lat;
    if (w >= 0 && w < 12 && t_v[w] == 1) begin
      o.wr_en   = 1'b1;
      o.wr_swap = 1'(t_swap[w]);
      o.wr_row  = 2'(t_row[w]);
      o.wr_col  = 2'(t_col[w]);
    end
    return o;
  endfunction

  function automatic out_t sample(input bit use3);
    out_t o;
    if (use3) begin
      o = '{bus3.busy_o, bus3.done_o, bus3.pe0_valid_o, bus3.pe1_valid_o, bus3.pe0_scheme_o,
            bus3.pe1_scheme_o, bus3.rd_en_o, bus3.src_fb_o, bus3.rd_swap_o, bus3.rd_row_o,
            bus3.rd_col_o, bus3.wr_en_o, bus3.wr_swap_o, bus3.wr_row_o, bus3.wr_col_o};
    end else begin
      o = '{bus8.busy_o, bus8.done_o, bus8.pe0_valid_o, bus8.pe1_valid_o, bus8.pe0_scheme_o,
            bus8.pe1_scheme_o, bus8.rd_en_o, bus8.src_fb_o, bus8.rd_swap_o, bus8.rd_row_o,
            bus8.rd_col_o, bus8.wr_en_o, bus8.wr_swap_o, bus8.wr_row_o, bus8.wr_col_o};
    end
    return o;
  endfunction

  task automatic test_reset();
    out_t obs;
    rst_n = 1'b0;
    bus8.start_i = 1'b0; bus8.abort_i = 1'b0;
    bus3.start_i = 1'b0; bus3.abort_i = 1'b0;
    repeat (3) @(negedge clk);
    obs = sample(1'b0); checks++;
    if (obs !== out_t'('0)) begin errors++; $display("[TB] FAIL reset_dut8: got %h expected %h", obs, out_t'('0)); end
    obs = sample(1'b1); checks++;
    if (obs !== out_t'('0)) begin errors++; $display("[TB] FAIL reset_dut3: got %h expected %h", obs, out_t'('0)); end
    rst_n = 1'b1;
    @(negedge clk);
    obs = sample(1'b0); checks++;
    if (obs !== out_t'('0)) begin errors++; $display("[TB] FAIL reset_idle: got %h expected %h", obs, out_t'('0)); end
  endtask

  task automatic test_reset_mid_run();
    out_t obs, exp;
    exp_q.delete();
    for (int k = 1; k <= 6; k++) exp_q.push_back(model(k, 8));
    exp_q.push_back('0);
    exp_q.push_back('0);
    bus8.start_i = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      bus8.start_i = 1'b0;
      obs = sample(1'b0); exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin errors++; $display("[TB] FAIL reset_mid_run k=%0d: got %h expected %h", k, obs, exp); end
      if (k == 6) rst_n = 1'b0;
      if (k == 7) rst_n = 1'b1;
    end
  endtask

  task automatic test_full_run();
    out_t obs, exp;
    exp_q.delete();
    for (int k = 1; k <= 23; k++) exp_q.push_back(model(k, 8));
    bus8.start_i = 1'b1;
    for (int k = 1; k <= 23; k++) begin
      @(negedge clk);
      bus8.start_i = 1'b0;
      obs = sample(1'b0); exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin errors++; $display("[TB] FAIL full_run k=%0d: got %h expected %h", k, obs, exp); end
    end
  endtask

  task automatic test_abort_run();
    out_t obs, exp;
    exp_q.delete();
    for (int k = 1; k <= 5; k++)  exp_q.push_back(model(k, 8));
    for (int k = 6; k <= 23; k++) exp_q.push_back('0);
    bus8.start_i = 1'b1;
    for (int k = 1; k <= 23; k++) begin
      @(negedge clk);
      bus8.start_i = 1'b0;
      obs = sample(1'b0); exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin errors++; $display("[TB] FAIL abort_run k=%0d: got %h expected %h", k, obs, exp); end
      bus8.abort_i = (k == 5);
    end
  endtask

  task automatic test_abort_drain();
    out_t obs, exp;
    exp_q.delete();
    for (int k = 1; k <= 15; k++)  exp_q.push_back(model(k, 8));
    for (int k = 16; k <= 24; k++) exp_q.push_back('0);
    bus8.start_i = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      bus8.start_i = 1'b0;
      obs = sample(1'b0); exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin errors++; $display("[TB] FAIL abort_drain k=%0d: got %h expected %h", k, obs, exp); end
      bus8.abort_i = (k == 15);
    end
  endtask

  task automatic test_back_to_back();
    out_t obs, exp;
    exp_q.delete();
    for (int k = 1; k <= 22; k++)  exp_q.push_back(model(k, 8));
    for (int k = 23; k <= 44; k++) exp_q.push_back(model(k - 22, 8));
    bus8.start_i = 1'b1;
    for (int k = 1; k <= 44; k++) begin
      @(negedge clk);
      obs = sample(1'b0); exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin errors++; $display("[TB] FAIL back_to_back k=%0d: got %h expected %h", k, obs, exp); end
      if (k == 23) bus8.start_i = 1'b0;
    end
  endtask

  task automatic test_start_abort_idle();
    out_t obs, exp;
    exp_q.delete();
    for (int k = 1; k <= 4; k++) exp_q.push_back('0);
    bus8.start_i = 1'b1;
    bus8.abort_i = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 2) begin bus8.start_i = 1'b0; bus8.abort_i = 1'b0; end
      obs = sample(1'b0); exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin errors++; $display("[TB] FAIL start_abort_idle k=%0d: got %h expected %h", k, obs, exp); end
    end
  endtask

  task automatic test_latency3();
    out_t obs, exp;
    exp_q.delete();
    for (int k = 1; k <= 18; k++) exp_q.push_back(model(k, 3));
    bus3.start_i = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      bus3.start_i = 1'b0;
      obs = sample(1'b1); exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin errors++; $display("[TB] FAIL latency3 k=%0d: got %h expected %h", k, obs, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_run();
    test_full_run();
    test_abort_run();
    test_abort_drain();
    test_back_to_back();
    test_start_abort_idle();
    test_latency3();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
